// File: rtl/cfginfo_apb.sv
// cfginfo_apb: read-only APB view of the elaborated core configuration,
// with a post-reset config checksum engine and one scratch register.
package cfginfo_pkg;

  typedef struct packed {
    logic [31:0] XLEN;
    logic [31:0] MISA;
    logic        ZICSR;
    logic        ZIFENCEI;
    logic        ZICNTR;
    logic        ZIHPM;
    logic        ZFH;
    logic        ZFA;
    logic        SSTC;
    logic        VIRTMEM;
    logic        BPRED_SUPPORTED;
    logic        DCACHE_SUPPORTED;
    logic        ICACHE_SUPPORTED;
    logic        BUS_SUPPORTED;
    logic        COMPRESSED_SUPPORTED;
    logic        ZICBOM;
    logic        ZICBOZ;
    logic [31:0] DCACHE_NUMWAYS;
    logic [31:0] DCACHE_WAYSIZEINBYTES;
    logic [31:0] DCACHE_LINELENINBITS;
    logic [31:0] DCACHE_REPL;
    logic [31:0] ICACHE_NUMWAYS;
    logic [31:0] ICACHE_WAYSIZEINBYTES;
    logic [31:0] ICACHE_LINELENINBITS;
    logic [31:0] ICACHE_REPL;
    logic [63:0] RESET_VECTOR;
    logic [31:0] ITLB_ENTRIES;
    logic [31:0] DTLB_ENTRIES;
    logic [31:0] PMP_ENTRIES;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    XLEN:                  32'd64,
    MISA:                  32'h0014_112D,
    ZICSR:                 1'b1,
    ZIFENCEI:              1'b1,
    ZICNTR:                1'b1,
    ZIHPM:                 1'b1,
    ZFH:                   1'b0,
    ZFA:                   1'b0,
    SSTC:                  1'b1,
    VIRTMEM:               1'b1,
    BPRED_SUPPORTED:       1'b1,
    DCACHE_SUPPORTED:      1'b1,
    ICACHE_SUPPORTED:      1'b1,
    BUS_SUPPORTED:         1'b1,
    COMPRESSED_SUPPORTED:  1'b1,
    ZICBOM:                1'b1,
    ZICBOZ:                1'b1,
    DCACHE_NUMWAYS:        32'd4,
    DCACHE_WAYSIZEINBYTES: 32'd4096,
    DCACHE_LINELENINBITS:  32'd512,
    DCACHE_REPL:           32'd1,
    ICACHE_NUMWAYS:        32'd4,
    ICACHE_WAYSIZEINBYTES: 32'd4096,
    ICACHE_LINELENINBITS:  32'd256,
    ICACHE_REPL:           32'd2,
    RESET_VECTOR:          64'h0000_0001_0000_1000,
    ITLB_ENTRIES:          32'd32,
    DTLB_ENTRIES:          32'd16,
    PMP_ENTRIES:           32'd16
  };

  typedef enum logic {IDLE, ACCESS} bus_st_t;
  typedef enum logic {CS_RUN, CS_DONE} cs_st_t;

endpackage

module cfginfo_apb
  import cfginfo_pkg::*;
#(
  parameter cfg_t P = CFG_DEFAULT,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);

  localparam logic [3:0] WS = WAIT_STATES[3:0];
  localparam logic [5:0] SCR_OFF = 6'h12;

  localparam logic [31:0] FEAT = {
    17'b0,
    P.ZICBOZ, P.ZICBOM,
    P.COMPRESSED_SUPPORTED,
    P.BUS_SUPPORTED,
    P.ICACHE_SUPPORTED,
    P.DCACHE_SUPPORTED,
    P.BPRED_SUPPORTED,
    P.VIRTMEM, P.SSTC,
    P.ZFA, P.ZFH,
    P.ZIHPM, P.ZICNTR,
    P.ZIFENCEI, P.ZICSR
  };

  function automatic logic [31:0] cfg_word(
    input logic [3:0] i
  );
    logic [31:0] w;
    w = '0;
    case (i)
      4'h0: w = 32'h5741_4C59;
      4'h1: w = P.XLEN;
      4'h2: w = P.MISA;
      4'h3: w = FEAT;
      4'h4: w = P.DCACHE_NUMWAYS;
      4'h5: w = P.DCACHE_WAYSIZEINBYTES;
      4'h6: w = P.DCACHE_LINELENINBITS;
      4'h7: w = P.DCACHE_REPL;
      4'h8: w = P.ICACHE_NUMWAYS;
      4'h9: w = P.ICACHE_WAYSIZEINBYTES;
      4'hA: w = P.ICACHE_LINELENINBITS;
      4'hB: w = P.ICACHE_REPL;
      4'hC: w = P.RESET_VECTOR[31:0];
      4'hD: w = P.RESET_VECTOR[63:32];
      4'hE: w = {P.DTLB_ENTRIES[15:0],
                 P.ITLB_ENTRIES[15:0]};
      4'hF: w = P.PMP_ENTRIES;
      default: w = '0;
    endcase
    return w;
  endfunction

  bus_st_t     st_q, st_d;
  cs_st_t      cs_q, cs_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  idx_q;
  logic [31:0] csum_q;
  logic [31:0] scratch_q;
  logic [31:0] prdata_q;
  logic        err_q;
  logic        setup;
  logic        wr_scr;
  logic        pready_c;
  logic        csum_ready;
  logic [5:0]  off;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign off         = PADDR[7:2];
  assign unused_addr = ^PADDR[1:0];
  assign csum_ready  = (cs_q == CS_DONE);

  // Read mux over the register map.
  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      off < 6'h10:   rd_word = cfg_word(off[3:0]);
      off == 6'h10:  rd_word = csum_q;
      off == 6'h11:  rd_word = {31'b0, csum_ready};
      off == SCR_OFF: rd_word = scratch_q;
      default:       rd_word = '0;
    endcase
  end

  // Bus FSM next state, wait counter and strobes.
  always_comb begin
    st_d     = st_q;
    wcnt_d   = wcnt_q;
    setup    = 1'b0;
    wr_scr   = 1'b0;
    pready_c = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          st_d   = ACCESS;
          wcnt_d = WS;
          setup  = 1'b1;
        end
      end
      ACCESS: begin
        pready_c = (wcnt_q == 4'd0);
        if (!PSEL) begin
          st_d = IDLE;
        end else if (pready_c) begin
          st_d   = IDLE;
          wr_scr = PWRITE && (off == SCR_OFF);
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      st_q   <= IDLE;
      wcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Response data/error latched at setup; scratch written on completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_q  <= '0;
      err_q     <= 1'b0;
      scratch_q <= '0;
    end else begin
      if (setup) begin
        err_q <= PWRITE && (off != SCR_OFF);
        if (!PWRITE) prdata_q <= rd_word;
      end
      if (wr_scr) begin
        for (int b = 0; b < 4; b++) begin
          if (PSTRB[b]) begin
            scratch_q[8*b +: 8] <= PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Checksum engine next state: stop after the last config word.
  always_comb begin
    cs_d = cs_q;
    if (cs_q == CS_RUN && idx_q == 4'hF) cs_d = CS_DONE;
  end

  // Checksum engine: rotate-xor one config word per cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cs_q   <= CS_RUN;
      idx_q  <= '0;
      csum_q <= '0;
    end else begin
      cs_q <= cs_d;
      if (cs_q == CS_RUN) begin
        csum_q <= {csum_q[30:0], csum_q[31]}
                  ^ cfg_word(idx_q);
        idx_q  <= idx_q + 4'd1;
      end
    end
  end

  assign PREADY  = pready_c;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pready_c & err_q;

endmodule

// File: tb/tb_cfginfo_apb.sv
// tb_cfginfo_apb: scoreboard bench for cfginfo_apb, one slow
// (1 wait state) and one fast (0 wait states) instance.
module tb_cfginfo_apb;

  localparam int WS_S = 1;
  localparam int WS_F = 0;

  localparam logic [31:0] CFG_TAB [16] = '{
    32'h5741_4C59, 32'h0000_0040,
    32'h0014_112D, 32'h0000_7FCF,
    32'h0000_0004, 32'h0000_1000,
    32'h0000_0200, 32'h0000_0001,
    32'h0000_0004, 32'h0000_1000,
    32'h0000_0100, 32'h0000_0002,
    32'h0000_1000, 32'h0000_0001,
    32'h0010_0020, 32'h0000_0010
  };

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        psel_s, psel_f;
  logic        penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready_s, pready_f;
  logic [31:0] prdata_s, prdata_f;
  logic        pslverr_s, pslverr_f;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc;

  cfginfo_apb #(.WAIT_STATES(WS_S)) u_slow (
    .PCLK(clk), .PRESETn(rst_n),
    .PSEL(psel_s), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready_s), .PRDATA(prdata_s),
    .PSLVERR(pslverr_s)
  );

  cfginfo_apb #(.WAIT_STATES(WS_F)) u_fast (
    .PCLK(clk), .PRESETn(rst_n),
    .PSEL(psel_f), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready_f), .PRDATA(prdata_f),
    .PSLVERR(pslverr_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] fold(input int n);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < n && i < 16; i++) begin
      c = {c[30:0], c[31]} ^ CFG_TAB[i];
    end
    return c;
  endfunction

  // kind 0: fixed expectation, 1: STATUS, 2: CHECKSUM
  task automatic apb_xfer(
    input bit          fast,
    input bit          wr,
    input logic [7:0]  addr,
    input logic [31:0] wdata,
    input logic [3:0]  strb,
    input logic [31:0] exp_d,
    input logic        exp_e,
    input int          kind,
    input string       nm
  );
    exp_t        e;
    int          lat;
    bit          rdy;
    logic [31:0] d;
    logic        er;
    @(negedge clk);
    psel_s  = !fast;
    psel_f  = fast;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    e.data = exp_d;
    if (kind == 1) e.data = {31'b0, cyc >= 16};
    if (kind == 2) e.data = fold(cyc);
    e.err = exp_e;
    e.chk = !wr;
    e.lat = (fast ? WS_F : WS_S) + 1;
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    lat = 0;
    rdy = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      if (i > 0) @(negedge clk);
      lat++;
      rdy = fast ? pready_f : pready_s;
    end
    d  = fast ? prdata_f : prdata_s;
    er = fast ? pslverr_f : pslverr_s;
    e  = sb.pop_front();
    checks++;
    if (!rdy || lat !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (ready=%0b) expected %0d",
               nm, lat, rdy, e.lat);
    end
    if (e.chk) begin
      checks++;
      if (d !== e.data) begin
        errors++;
        $display("FAIL %s data: got %h expected %h",
                 nm, d, e.data);
      end
    end
    checks++;
    if (er !== e.err) begin
      errors++;
      $display("FAIL %s pslverr: got %b expected %b",
               nm, er, e.err);
    end
    @(posedge clk);
    #1;
    psel_s  = 1'b0;
    psel_f  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic poll_ready(input string nm);
    bit seen0, seen1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < 12 && !seen1; i++) begin
      apb_xfer(0, 0, 8'h44, '0, '0, '0, 0, 1, nm);
      if (prdata_s[0] === 1'b1) seen1 = 1'b1;
      else                      seen0 = 1'b1;
    end
    checks++;
    if (!(seen0 && seen1)) begin
      errors++;
      $display("FAIL %s sequence: saw0=%0b saw1=%0b expected 1 1",
               nm, seen0, seen1);
    end
    apb_xfer(0, 0, 8'h40, '0, '0, '0, 0, 2, {nm, "_csum"});
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    psel_s  = 1'b0;
    psel_f  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (pready_s !== 1'b0 || pready_f !== 1'b0) begin
      errors++;
      $display("FAIL rst_pready: got %b%b expected 00",
               pready_s, pready_f);
    end
    if (prdata_s !== '0 || prdata_f !== '0) begin
      errors++;
      $display("FAIL rst_prdata: got %h %h expected 0",
               prdata_s, prdata_f);
    end
    if (pslverr_s !== 1'b0 || pslverr_f !== 1'b0) begin
      errors++;
      $display("FAIL rst_pslverr: got %b%b expected 00",
               pslverr_s, pslverr_f);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_id();
    apb_xfer(0, 0, 8'h00, '0, '0, 32'h5741_4C59, 0, 0, "id");
  endtask

  task automatic test_scratch();
    apb_xfer(0, 1, 8'h48, 32'hDEAD_BEEF, 4'b0011, '0, 0, 0, "scr_wr");
    apb_xfer(0, 0, 8'h48, '0, '0, 32'h0000_BEEF, 0, 0, "scr_rd");
    apb_xfer(0, 1, 8'h4B, 32'hCAFE_0000, 4'b1100, '0, 0, 0, "scr_wr_hi");
    apb_xfer(0, 0, 8'h49, '0, '0, 32'hCAFE_BEEF, 0, 0, "scr_rd_hi");
    apb_xfer(0, 1, 8'h04, 32'h1234_5678, 4'hF, '0, 1, 0, "ro_wr");
    apb_xfer(0, 0, 8'h04, '0, '0, 32'h0000_0040, 0, 0, "xlen_rd");
  endtask

  task automatic test_checksum();
    do_reset();
    apb_xfer(0, 0, 8'h40, '0, '0, '0, 0, 2, "csum_part");
    poll_ready("status");
  endtask

  task automatic test_map();
    apb_xfer(0, 0, 8'h08, '0, '0, 32'h0014_112D, 0, 0, "misa");
    apb_xfer(0, 0, 8'h0C, '0, '0, 32'h0000_7FCF, 0, 0, "feat");
    apb_xfer(0, 0, 8'h1C, '0, '0, 32'h0000_0001, 0, 0, "d_repl");
    apb_xfer(0, 0, 8'h2C, '0, '0, 32'h0000_0002, 0, 0, "i_repl");
    apb_xfer(0, 0, 8'h30, '0, '0, 32'h0000_1000, 0, 0, "rv_lo");
    apb_xfer(0, 0, 8'h34, '0, '0, 32'h0000_0001, 0, 0, "rv_hi");
    apb_xfer(0, 0, 8'h38, '0, '0, 32'h0010_0020, 0, 0, "tlb");
    apb_xfer(0, 0, 8'h3C, '0, '0, 32'h0000_0010, 0, 0, "pmp");
    apb_xfer(0, 0, 8'h7C, '0, '0, 32'h0000_0000, 0, 0, "unmap");
  endtask

  task automatic test_back_to_back();
    apb_xfer(1, 0, 8'h10, '0, '0, 32'h0000_0004, 0, 0, "b2b_dways");
    apb_xfer(1, 0, 8'h20, '0, '0, 32'h0000_0004, 0, 0, "b2b_iways");
    apb_xfer(1, 0, 8'h28, '0, '0, 32'h0000_0100, 0, 0, "b2b_iline");
    apb_xfer(1, 1, 8'h14, 32'hFFFF_FFFF, 4'hF, '0, 1, 0, "b2b_rowr");
    apb_xfer(1, 0, 8'h14, '0, '0, 32'h0000_1000, 0, 0, "b2b_dsize");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 40 && cyc != 5; i++) @(negedge clk);
    psel_s  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h48;
    pwdata  = 32'hFFFF_FFFF;
    pstrb   = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pready_s !== 1'b0 || pslverr_s !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got ready=%b err=%b expected 0 0",
               pready_s, pslverr_s);
    end
    psel_s  = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apb_xfer(0, 0, 8'h48, '0, '0, 32'h0000_0000, 0, 0, "midrst_scr");
    poll_ready("midrst_status");
  endtask

  initial begin
    test_reset();
    test_id();
    test_scratch();
    test_checksum();
    test_map();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
